apb_master_bridge: RTL
======================

Name: apb_master_bridge

Overview:
- Converts a valid/ready request/response channel (core load/store path) into single APB transfers toward one APB slave (e.g. the RAM model).
- Sits directly upstream of the APB memory/peripheral slaves.
- One outstanding transfer at a time; no pipelining across transfers.

Parameters:
ADDR_W, 32, width of request address and paddr
TIMEOUT_CYCLES, 256, maximum ACCESS-phase wait cycles before forced error (only with APB_TIMEOUT_EN)

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  bridge can accept request
req_addr  input  ADDR_W  byte address
req_write  input  1  1=write, 0=read
req_wdata  input  32  write data
req_wstrb  input  4  byte strobes for writes
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_rdata  output  32  read data (0 for writes)
rsp_err  output  1  slave error or timeout
psel  output  1  APB select
penable  output  1  APB enable
paddr  output  ADDR_W  APB address
pwrite  output  1  APB direction
pwdata  output  32  APB write data
pwstrb  output  4  APB strobes
pready  input  1  APB ready
prdata  input  32  APB read data
pslverr  input  1  APB error

Behaviour:
- Clock is clk; reset is rst_n, asynchronous, active-low. Reset forces state IDLE, all registered outputs 0: psel, penable, paddr, pwrite, pwdata, pwstrb, rsp_valid, rsp_rdata, rsp_err.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready=1 (req_ready is 1 only in IDLE).
  - On req_valid & req_ready: register addr/write/wdata onto paddr/pwrite/pwdata; pwstrb=req_wstrb if write, else 4'b0.
  - Next state SETUP; psel=1, penable=0.
- SETUP: exactly one cycle; next ACCESS, penable=1.
- ACCESS:
  - Hold psel=1, penable=1; paddr/pwrite/pwdata/pwstrb stable.
  - When pready=1: capture rsp_rdata = pwrite ? 0 : prdata and rsp_err = pslverr.
  - Same edge: drop psel and penable, set rsp_valid=1, go RESP.
- RESP:
  - rsp_valid held with rsp_rdata/rsp_err stable until rsp_ready=1.
  - On that edge: clear rsp_valid, go IDLE.
  - rsp_ready while rsp_valid=0 is ignored.
- APB address/data regs retain last value after transfer; only psel/penable clear.
- Latency with zero-wait slave: accept at edge 0, psel at cycle 1, penable at cycle 2, rsp_valid at cycle 3. Each pready wait cycle adds 1. Minimum 4 cycles per transfer with rsp_ready=1.
- req_* inputs are ignored outside IDLE.
- paddr is passed unmodified; no alignment check, no address decode.
- pslverr is sampled only when pready=1 in ACCESS.
- Reset mid-transfer: psel/penable/rsp_valid drop asynchronously; the transfer is abandoned with no response.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - Wait counter cleared on entering ACCESS, increments each ACCESS cycle with pready=0.
  - When counter reaches TIMEOUT_CYCLES-1 with pready=0: complete as if pready with rsp_err=1, rsp_rdata=0, drop psel/penable, go RESP.
  - If pready=1 in that same cycle, the normal completion wins.
- Undefined: no counter; ACCESS waits indefinitely for pready.

Test Plan:
- Write 0xDEADBEEF to 0x100, strb 0xF, RAM slave, rsp_ready=1 -> psel at cycle 1, penable at cycle 2, rsp_valid at cycle 3, rsp_err=0; subsequent read of 0x100 returns 0xDEADBEEF. Then write strb 0x2 data 0x0000AA00 -> read returns 0xDEADAAEF.
- Read 0x40 from slave holding pready=0 for 3 ACCESS cycles, prdata=0x12345678 -> paddr/penable stable throughout, rsp_valid at cycle 6, rsp_rdata=0x12345678, pwstrb=0.
- Write to 0x0010_0000 (out of range, slave pslverr=1) -> rsp_err=1, rsp_rdata=0.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid, req_valid held high -> rsp_valid/rsp_rdata stable, req_ready=0, psel=0. Second request accepted only in the IDLE cycle after rsp_ready=1.
- Assert rst_n=0 during ACCESS -> psel, penable, rsp_valid 0 immediately (before next clk edge); after release, req_ready=1 and a new write completes normally.
- With APB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never asserts pready -> rsp_valid after 8 ACCESS cycles with rsp_err=1, rsp_rdata=0. Without the macro -> still waiting after 1000 cycles.

Source files
------------

// File: rtl/apb_master_bridge_if.sv
// Request/response channel plus APB bus bundle for apb_master_bridge.
// Modport master is the bridge side; modport slave is the core/APB side.
interface apb_master_bridge_if #(
   parameter int ADDR_W = 32
);
   // request channel
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic              req_write;
   logic [31:0]       req_wdata;
   logic [3:0]        req_wstrb;
   // response channel
   logic              rsp_valid;
   logic              rsp_ready;
   logic [31:0]       rsp_rdata;
   logic              rsp_err;
   // APB
   logic              psel;
   logic              penable;
   logic [ADDR_W-1:0] paddr;
   logic              pwrite;
   logic [31:0]       pwdata;
   logic [3:0]        pwstrb;
   logic              pready;
   logic [31:0]       prdata;
   logic              pslverr;

   modport master (
      input  req_valid, req_addr, req_write,
      input  req_wdata, req_wstrb, rsp_ready,
      input  pready, prdata, pslverr,
      output req_ready, rsp_valid, rsp_rdata,
      output rsp_err, psel, penable, paddr,
      output pwrite, pwdata, pwstrb
   );

   modport slave (
      output req_valid, req_addr, req_write,
      output req_wdata, req_wstrb, rsp_ready,
      output pready, prdata, pslverr,
      input  req_ready, rsp_valid, rsp_rdata,
      input  rsp_err, psel, penable, paddr,
      input  pwrite, pwdata, pwstrb
   );
endinterface

// File: rtl/apb_master_bridge.sv
// Valid/ready request channel to single APB transfers, one at a time.
// Ports: clk, rst_n (async low), bus (apb_master_bridge_if.master).
// Optional macro APB_TIMEOUT_EN: ACCESS wait limit of TIMEOUT_CYCLES.
module apb_master_bridge #(
   parameter int ADDR_W = 32
`ifdef APB_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 256
`endif
) (
   input logic clk,
   input logic rst_n,
   apb_master_bridge_if.master bus
);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      RESP
   } state_t;

   state_t            r_state, w_next;
   logic              r_psel, w_psel;
   logic              r_penable, w_penable;
   logic [ADDR_W-1:0] r_paddr, w_paddr;
   logic              r_pwrite, w_pwrite;
   logic [31:0]       r_pwdata, w_pwdata;
   logic [3:0]        r_pwstrb, w_pwstrb;
   logic              r_valid, w_valid;
   logic [31:0]       r_rdata, w_rdata;
   logic              r_err, w_err;
   logic              w_done;

`ifdef APB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CNT_W-1:0] LAST =
      CNT_W'(TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0] r_wait, w_wait;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_psel    <= 1'b0;
         r_penable <= 1'b0;
         r_paddr   <= '0;
         r_pwrite  <= 1'b0;
         r_pwdata  <= '0;
         r_pwstrb  <= '0;
         r_valid   <= 1'b0;
         r_rdata   <= '0;
         r_err     <= 1'b0;
`ifdef APB_TIMEOUT_EN
         r_wait    <= '0;
`endif
      end else begin
         r_state   <= w_next;
         r_psel    <= w_psel;
         r_penable <= w_penable;
         r_paddr   <= w_paddr;
         r_pwrite  <= w_pwrite;
         r_pwdata  <= w_pwdata;
         r_pwstrb  <= w_pwstrb;
         r_valid   <= w_valid;
         r_rdata   <= w_rdata;
         r_err     <= w_err;
`ifdef APB_TIMEOUT_EN
         r_wait    <= w_wait;
`endif
      end
   end

   always_comb begin
      w_next    = r_state;
      w_psel    = r_psel;
      w_penable = r_penable;
      w_paddr   = r_paddr;
      w_pwrite  = r_pwrite;
      w_pwdata  = r_pwdata;
      w_pwstrb  = r_pwstrb;
      w_valid   = r_valid;
      w_rdata   = r_rdata;
      w_err     = r_err;
      w_done    = 1'b0;
`ifdef APB_TIMEOUT_EN
      w_wait    = r_wait;
`endif
      unique case (r_state)
         IDLE: begin
            if (bus.req_valid) begin
               w_paddr  = bus.req_addr;
               w_pwrite = bus.req_write;
               w_pwdata = bus.req_wdata;
               w_pwstrb = bus.req_write ?
                          bus.req_wstrb : 4'b0;
               w_psel   = 1'b1;
               w_next   = SETUP;
            end
         end
         SETUP: begin
            w_penable = 1'b1;
            w_next    = ACCESS;
`ifdef APB_TIMEOUT_EN
            w_wait    = '0;
`endif
         end
         ACCESS: begin
            w_done = bus.pready;
`ifdef APB_TIMEOUT_EN
            if (!bus.pready) begin
               if (r_wait == LAST) w_done = 1'b1;
               else w_wait = r_wait + 1'b1;
            end
`endif
            // a timeout completion has pready=0: error, no data
            if (w_done) begin
               w_rdata   = (r_pwrite || !bus.pready) ?
                           32'h0 : bus.prdata;
               w_err     = bus.pslverr || !bus.pready;
               w_psel    = 1'b0;
               w_penable = 1'b0;
               w_valid   = 1'b1;
               w_next    = RESP;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               w_valid = 1'b0;
               w_next  = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   assign bus.req_ready = (r_state == IDLE);
   assign bus.psel      = r_psel;
   assign bus.penable   = r_penable;
   assign bus.paddr     = r_paddr;
   assign bus.pwrite    = r_pwrite;
   assign bus.pwdata    = r_pwdata;
   assign bus.pwstrb    = r_pwstrb;
   assign bus.rsp_valid = r_valid;
   assign bus.rsp_rdata = r_rdata;
   assign bus.rsp_err   = r_err;

endmodule
